// File: rtl/move_scheduler.sv
// move_scheduler: synchronizes/debounces four active-low buttons and issues start/move commands over valid/ready.
// Optional 2-entry command queue for presses arriving during ISSUE: define MOVE_SCHED_QUEUE_EN.
module move_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_mov_right,
  input  logic       i_mov_left,
  input  logic       i_mov_up,
  input  logic       i_mov_down,
  input  logic       i_win,
  input  logic       i_defeat,
  input  logic       i_cmd_ready,
  output logic       o_cmd_valid,
  output logic       o_cmd_start,
  output logic [1:0] o_cmd_dir,
  output logic       o_locked,
  output logic [7:0] o_dropped_cnt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_ISSUE, S_OVER} state_t;

  logic [3:0]    w_btnN;
  logic [3:0]    r_sync1, r_sync2, r_db, r_dbPrev;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_ev;
  logic          w_anyEv, w_gameOver;
  logic [2:0]    w_evCount, w_lose, w_dropInc;
  logic [1:0]    w_winDir;
  logic [8:0]    w_dropSum;

  state_t     r_state, w_stateNext;
  logic       r_cmdStart, w_startNext;
  logic [1:0] r_cmdDir, w_dirNext;
  logic [7:0] r_dropped;
`ifdef MOVE_SCHED_QUEUE_EN
  logic [1:0] r_q0, r_q1, r_qCount, w_q0Next, w_q1Next, w_qCountNext;
`endif

  // Bit order is also the arbitration order: right, left, up, down.
  assign w_btnN = {i_mov_down, i_mov_up, i_mov_left, i_mov_right};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_db     <= '1;
      r_dbPrev <= '1;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1  <= w_btnN;
      r_sync2  <= r_sync1;
      r_dbPrev <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press is a debounced 1->0 edge, seen one cycle after the debounced level flips.
  assign w_ev       = r_dbPrev & ~r_db;
  assign w_anyEv    = |w_ev;
  assign w_evCount  = {2'b0, w_ev[0]} + {2'b0, w_ev[1]} + {2'b0, w_ev[2]} + {2'b0, w_ev[3]};
  assign w_lose     = w_evCount - 3'd1;
  assign w_gameOver = i_win | i_defeat;

  always_comb begin
    w_winDir = 2'd0;
    if (w_ev[0])      w_winDir = 2'd0;
    else if (w_ev[1]) w_winDir = 2'd1;
    else if (w_ev[2]) w_winDir = 2'd2;
    else if (w_ev[3]) w_winDir = 2'd3;
  end

  always_comb begin
    w_stateNext = r_state;
    w_startNext = r_cmdStart;
    w_dirNext   = r_cmdDir;
    w_dropInc   = 3'd0;
`ifdef MOVE_SCHED_QUEUE_EN
    w_q0Next     = r_q0;
    w_q1Next     = r_q1;
    w_qCountNext = r_qCount;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_anyEv) begin
          w_stateNext = S_ISSUE;
          w_startNext = 1'b1;
          w_dirNext   = 2'd0;
          w_dropInc   = w_lose;
        end
      end
      S_READY: begin
        if (w_gameOver) begin
          w_stateNext = S_OVER;
        end else if (w_anyEv) begin
          w_stateNext = S_ISSUE;
          w_startNext = 1'b0;
          w_dirNext   = w_winDir;
          w_dropInc   = w_lose;
        end
      end
      S_ISSUE: begin
        // Game over takes precedence over a simultaneous transfer.
        if (w_gameOver) begin
          w_stateNext = S_OVER;
          w_startNext = 1'b0;
          w_dirNext   = 2'd0;
`ifdef MOVE_SCHED_QUEUE_EN
          w_qCountNext = 2'd0;
`endif
        end else begin
`ifdef MOVE_SCHED_QUEUE_EN
          if (i_cmd_ready) begin
            w_startNext = 1'b0;
            if (r_qCount != 2'd0) begin
              w_dirNext    = r_q0;
              w_q0Next     = r_q1;
              w_qCountNext = r_qCount - 2'd1;
              if (w_anyEv) begin
                if (r_qCount == 2'd1) w_q0Next = w_winDir;
                else                  w_q1Next = w_winDir;
                w_qCountNext = r_qCount;
                w_dropInc    = w_lose;
              end
            end else if (w_anyEv) begin
              w_dirNext = w_winDir;
              w_dropInc = w_lose;
            end else begin
              w_stateNext = S_READY;
              w_dirNext   = 2'd0;
            end
          end else if (w_anyEv) begin
            if (r_qCount == 2'd2) begin
              w_dropInc = w_evCount;
            end else begin
              if (r_qCount == 2'd0) w_q0Next = w_winDir;
              else                  w_q1Next = w_winDir;
              w_qCountNext = r_qCount + 2'd1;
              w_dropInc    = w_lose;
            end
          end
`else
          if (i_cmd_ready) begin
            w_stateNext = S_READY;
            w_startNext = 1'b0;
            w_dirNext   = 2'd0;
          end
          w_dropInc = w_evCount;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  assign w_dropSum = {1'b0, r_dropped} + {6'b0, w_dropInc};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cmdStart <= 1'b0;
      r_cmdDir   <= 2'd0;
      r_dropped  <= 8'd0;
`ifdef MOVE_SCHED_QUEUE_EN
      r_q0       <= 2'd0;
      r_q1       <= 2'd0;
      r_qCount   <= 2'd0;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_cmdStart <= w_startNext;
      r_cmdDir   <= w_dirNext;
      r_dropped  <= w_dropSum[8] ? 8'hFF : w_dropSum[7:0];
`ifdef MOVE_SCHED_QUEUE_EN
      r_q0       <= w_q0Next;
      r_q1       <= w_q1Next;
      r_qCount   <= w_qCountNext;
`endif
    end
  end

  assign o_cmd_valid   = (r_state == S_ISSUE);
  assign o_cmd_start   = r_cmdStart;
  assign o_cmd_dir     = r_cmdDir;
  assign o_locked      = (r_state == S_OVER);
  assign o_dropped_cnt = r_dropped;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed testbench for move_scheduler: latency, arbitration, queueing, drop saturation and game-over lockout.
module tb_move_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] btnN;
  logic       win, defeat, cmdReady;
  logic       cmdValid, cmdStart, locked;
  logic [1:0] cmdDir;
  logic [7:0] droppedCnt;

  int checkCount = 0;
  int errorCount = 0;

  int         xferCount;
  int         xferStarts;
  logic [1:0] xferDir [0:7];

`ifdef MOVE_SCHED_QUEUE_EN
  localparam int EXP_XFERS = 3;
  localparam int EXP_DROP5 = 2;
`else
  localparam int EXP_XFERS = 1;
  localparam int EXP_DROP5 = 4;
`endif

  move_scheduler #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_mov_right  (btnN[0]),
    .i_mov_left   (btnN[1]),
    .i_mov_up     (btnN[2]),
    .i_mov_down   (btnN[3]),
    .i_win        (win),
    .i_defeat     (defeat),
    .i_cmd_ready  (cmdReady),
    .o_cmd_valid  (cmdValid),
    .o_cmd_start  (cmdStart),
    .o_cmd_dir    (cmdDir),
    .o_locked     (locked),
    .o_dropped_cnt(droppedCnt)
  );

  // 20 ns clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Counts every comparison and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, leaving the bench 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a button pattern low for lowCycles edges, then release and let it settle
  task automatic applyStimulus(input logic [3:0] pressN, input int lowCycles, input int relCycles);
    btnN = pressN;
    tick(lowCycles);
    btnN = 4'hF;
    tick(relCycles);
  endtask

  // Record every handshake over a window; buttons are released at releaseAt (negative: never)
  task automatic collectTransfers(input int cycles, input int releaseAt);
    xferCount  = 0;
    xferStarts = 0;
    for (int i = 0; i < cycles; i++) begin
      if (i == releaseAt) btnN = 4'hF;
      if (cmdValid && cmdReady) begin
        if (xferCount < 8) xferDir[xferCount] = cmdDir;
        if (cmdStart) xferStarts++;
        xferCount++;
      end
      tick(1);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"},   32'(cmdValid),   32'd0);
    checkOutput({tag, "_start"},   32'(cmdStart),   32'd0);
    checkOutput({tag, "_dir"},     32'(cmdDir),     32'd0);
    checkOutput({tag, "_locked"},  32'(locked),     32'd0);
    checkOutput({tag, "_dropped"}, 32'(droppedCnt), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    btnN     = 4'hF;
    win      = 1'b0;
    defeat   = 1'b0;
    cmdReady = 1'b0;
    tick(3);
    checkResetValues("reset");
    reset = 1'b0;
    tick(2);

    // Start command appears exactly on the 7th edge after right is first sampled low
    $display("[TB] start command latency");
    btnN = 4'b1110;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 5) btnN = 4'hF;
      if (i == 6) checkOutput("lat_edge6_valid", 32'(cmdValid), 32'd0);
    end
    checkOutput("lat_edge7_valid", 32'(cmdValid), 32'd1);
    checkOutput("lat_edge7_start", 32'(cmdStart), 32'd1);
    checkOutput("lat_edge7_dir",   32'(cmdDir),   32'd0);
    tick(4);
    checkOutput("hold_valid", 32'(cmdValid), 32'd1);
    checkOutput("hold_start", 32'(cmdStart), 32'd1);
    cmdReady = 1'b1;
    tick(1);
    checkOutput("xfer_fall_valid", 32'(cmdValid), 32'd0);
    tick(8);
    checkOutput("no_more_valid", 32'(cmdValid), 32'd0);
    checkOutput("start_dropped", 32'(droppedCnt), 32'd0);

    // Single down press with ready high
    $display("[TB] down press");
    btnN = 4'b0111;
    collectTransfers(20, 5);
    checkOutput("down_xfers", 32'(xferCount), 32'd1);
    checkOutput("down_dir",   32'(xferDir[0]), 32'd3);
    checkOutput("down_start", 32'(xferStarts), 32'd0);

    // 5 ns glitch never reaches a sampling edge
    btnN[1] = 1'b0;
    #5;
    btnN[1] = 1'b1;
    collectTransfers(14, -1);
    checkOutput("glitch_xfers", 32'(xferCount), 32'd0);

    // Simultaneous left+up: left wins, up is dropped
    $display("[TB] simultaneous left and up");
    btnN = 4'b1001;
    collectTransfers(20, 5);
    checkOutput("arb_xfers",   32'(xferCount), 32'd1);
    checkOutput("arb_dir",     32'(xferDir[0]), 32'd1);
    checkOutput("arb_dropped", 32'(droppedCnt), 32'd1);

    // Presses during a stalled ISSUE
    $display("[TB] presses while stalled");
    cmdReady = 1'b0;
    applyStimulus(4'b1101, 5, 8);
    checkOutput("stall_valid", 32'(cmdValid), 32'd1);
    checkOutput("stall_dir",   32'(cmdDir),   32'd1);
    applyStimulus(4'b1011, 5, 8);
    applyStimulus(4'b0111, 5, 8);
    applyStimulus(4'b1110, 5, 8);
    checkOutput("stall_dropped", 32'(droppedCnt), 32'(EXP_DROP5));
    checkOutput("stall_dir_held", 32'(cmdDir), 32'd1);
    cmdReady = 1'b1;
    collectTransfers(10, -1);
    checkOutput("drain_xfers", 32'(xferCount), 32'(EXP_XFERS));
    checkOutput("drain_dir0",  32'(xferDir[0]), 32'd1);
`ifdef MOVE_SCHED_QUEUE_EN
    checkOutput("drain_dir1",  32'(xferDir[1]), 32'd2);
    checkOutput("drain_dir2",  32'(xferDir[2]), 32'd3);
`endif
    checkOutput("drain_idle_valid", 32'(cmdValid), 32'd0);

    // Drop counter saturates at 255
    $display("[TB] drop counter saturation");
    cmdReady = 1'b0;
    applyStimulus(4'b1110, 5, 8);
    for (int i = 0; i < 80; i++) applyStimulus(4'b0000, 5, 8);
    checkOutput("sat_dropped", 32'(droppedCnt), 32'd255);
    cmdReady = 1'b1;
    collectTransfers(10, -1);
    checkOutput("sat_drain_valid", 32'(cmdValid), 32'd0);
    checkOutput("sat_after_drain", 32'(droppedCnt), 32'd255);

    // Win with ready high in ISSUE: game over, no transfer
    $display("[TB] win lockout");
    cmdReady = 1'b0;
    applyStimulus(4'b1011, 5, 8);
    checkOutput("pre_win_valid", 32'(cmdValid), 32'd1);
    checkOutput("pre_win_dir",   32'(cmdDir),   32'd2);
    win      = 1'b1;
    cmdReady = 1'b1;
    tick(1);
    checkOutput("win_valid",  32'(cmdValid), 32'd0);
    checkOutput("win_locked", 32'(locked),   32'd1);
    btnN = 4'b1110;
    collectTransfers(20, 5);
    checkOutput("locked_xfers",  32'(xferCount), 32'd0);
    checkOutput("locked_still",  32'(locked),    32'd1);

    // Reset clears everything; win held high is ignored in IDLE
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    checkResetValues("post_reset");

    // Defeat in READY also locks
    $display("[TB] defeat lockout");
    win  = 1'b0;
    btnN = 4'b1110;
    collectTransfers(20, 5);
    checkOutput("def_start_xfers", 32'(xferCount),  32'd1);
    checkOutput("def_start_flag",  32'(xferStarts), 32'd1);
    defeat = 1'b1;
    tick(1);
    checkOutput("def_locked", 32'(locked),   32'd1);
    checkOutput("def_valid",  32'(cmdValid), 32'd0);
    defeat = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Global watchdog so the run always ends on its own
  initial begin
    #2000000;
    errorCount++;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Turns the four raw, active-low direction buttons into a clean stream of one-at-a-time commands for the 2048 game FSM. It synchronizes and debounces the buttons, detects presses, and arbitrates presses that arrive together. It issues a start command first, then move commands, over a valid/ready handshake. It sits between the board push-buttons and the game FSM's move inputs and locks out all input once the FSM reports `win` or `defeat`.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive synchronized cycles a level must hold to be accepted (≥2)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `mov_right`, `mov_left`, `mov_up`, `mov_down`  in  1 each  raw buttons, active-low, asynchronous
- `win`, `defeat`  in  1 each  game-over flags from the game FSM, level
- `cmd_ready`  in  1  game FSM accepts the command
- `cmd_valid`  out  1  command pending
- `cmd_start`  out  1  pending command is "start game"; qualified by `cmd_valid`
- `cmd_dir`  out  2  direction: 00 right, 01 left, 10 up, 11 down; qualified by `cmd_valid`; 00 when `cmd_start`
- `locked`  out  1  game over, input ignored
- `dropped_cnt`  out  8  press events discarded, saturating at 255

## Operation
- Each button passes through a 2-flop synchronizer, then a per-button debouncer with its own counter.
  - The debounced level flips only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing cycle clears the counter.
- A press event is a debounced 1→0 transition, one event per press regardless of hold time. Releases produce no event.
- Same-cycle events are resolved by fixed priority: right > left > up > down. Each losing event increments `dropped_cnt`.
- FSM states:
  - **IDLE** (after reset): any event loads a start command (`cmd_start`=1) and goes to ISSUE.
  - **READY**: an event loads its direction and goes to ISSUE.
  - **ISSUE**: `cmd_valid`=1; `cmd_start`/`cmd_dir` are held stable until the transfer edge (`cmd_valid`&`cmd_ready`).
    - After the transfer, go to READY, or stay in ISSUE with the next queued command (see Configuration).
    - Events arriving in ISSUE go to the queue if it is compiled in and not full; otherwise they are dropped and counted.
  - **OVER**: entered from READY or ISSUE when `win` or `defeat` is sampled high.
    - Any pending command is withdrawn without transfer and the queue is flushed.
    - `locked`=1; events are ignored and not counted.
    - Exit is by `reset` only.
- `win`/`defeat` are ignored in IDLE.
- If `win`/`defeat` and `cmd_ready` are both high in ISSUE, game over wins: no transfer occurs.
- `dropped_cnt` saturates at 255 and never wraps.

## Timing
- Reset values: `cmd_valid`=0, `cmd_start`=0, `cmd_dir`=00, `locked`=0, `dropped_cnt`=0. Debounced levels and synchronizers reset to 1 (released), counters to 0, queue empty, state IDLE.
- Press latency: `cmd_valid` rises exactly 2+`DEBOUNCE_CYCLES`+1 rising edges after the first edge that samples the button low. That is 7 edges at the default.
- `cmd_valid` falls on the edge after the transfer edge unless a queued command follows. In that case it stays high and the payload changes on the cycle after the transfer edge.
- `locked` rises and `cmd_valid` falls on the edge after `win`/`defeat` is first sampled high.
- A `reset` asserted mid-handshake clears all state at that edge. `cmd_valid` is 0 the following cycle.

## Configuration
- `MOVE_SCHED_QUEUE_EN` defined: a 2-entry FIFO holds events that arrive during ISSUE.
  - On a transfer edge with the queue non-empty, the head becomes the next command back-to-back.
  - An event on a transfer edge with an empty queue becomes the next command directly.
  - An event with the queue full is dropped and counted.
- `MOVE_SCHED_QUEUE_EN` undefined: no FIFO. Every event seen in ISSUE, including on the transfer edge, is dropped and counted.

## Test plan
- Reset, hold `cmd_ready`=0, press `mov_right` low for 100 ns at 20 ns clock → `cmd_valid`=1, `cmd_start`=1 on the 7th edge; it holds until `cmd_ready`=1, then falls one cycle later with no further command.
- After start, pulse `mov_down` low 100 ns with `cmd_ready`=1 → one transfer with `cmd_dir`=11. A 5 ns glitch on `mov_left` produces no command.
- In READY, drop `mov_left` and `mov_up` on the same edge → single command `cmd_dir`=01; `dropped_cnt`=1.
- With `cmd_ready`=0 in ISSUE, press up, then down, then right:
  - queue defined: after ready, up (10) and down (11) issue back-to-back; `dropped_cnt`+1.
  - queue undefined: `dropped_cnt`+3.
- Raise `win` while `cmd_valid`=1 → next cycle `cmd_valid`=0, `locked`=1. Further presses change nothing until `reset`, after which all outputs return to reset values.
